// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch FSM states; HALT is only reachable when halt support is built in.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Instruction word that stops fetching when halt support is built in.
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    // PC loaded on reset; must be word aligned.
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // Word-address width of the instruction memory.
    localparam int          IM_AW     = 5;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captured instruction, its PC and PC+4, plus valid.
// Latency: one cycle from load to outputs.
// Backpressure: none internally; caller holds by leaving load and flush low.
module if_id_reg
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    // Flush wins over load; data is kept on flush since only valid matters.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_inst  <= 32'h0000_0000;
            id_pc    <= 32'h0000_0000;
            id_pc4   <= 32'h0000_0004;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid <= 1'b1;
            id_inst  <= inst;
            id_pc    <= pc;
            id_pc4   <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, FSM and IM addressing feeding the IF/ID register; halt support via FETCH_HALT_EN.
// Latency: address in cycle n, instruction in IF/ID after edge n+1; redirect costs one bubble.
// Backpressure: valid/ready toward decode; while stalled the PC and addresIM hold.
module instruction_fetch
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [IM_AW-1:0] addresIM,
    input  logic [31:0]      inst,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc4,
    output logic             halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target_al;
    logic         stall;
    logic         advance;
    logic         halt_hit;
    logic         cap_load;
    logic         cap_flush;

    // IM is read asynchronously straight off the PC; the index wraps at the IM size.
    assign addresIM  = pc[IM_AW+1:2];
    assign target_al = {branch_target[31:2], 2'b00};

    // Redirect beats stall beats advance; only RUN captures.
    assign stall     = id_valid && !id_ready;
    assign advance   = (state == ST_RUN) && !branch_taken && !stall;

`ifdef FETCH_HALT_EN
    logic halted_q;
    assign halt_hit  = advance && (inst == HALT_WORD);
    assign halted    = halted_q;
    // In HALT the last entry drains to decode, then valid drops.
    assign cap_flush = ((state == ST_RUN) && branch_taken) || halt_hit ||
                       ((state == ST_HALT) && id_valid && id_ready);
`else
    assign halt_hit  = 1'b0;
    assign halted    = 1'b0;
    assign cap_flush = (state == ST_RUN) && branch_taken;
`endif

    assign cap_load  = advance && !halt_hit;

    // FSM and PC: BOOT takes one cycle (honouring a redirect), RUN fetches, HALT freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                    if (branch_taken) begin
                        pc <= target_al;
                    end
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        pc <= target_al;
                    end else if (halt_hit) begin
                        state    <= ST_HALT;
`ifdef FETCH_HALT_EN
                        halted_q <= 1'b1;
`endif
                    end else if (advance) begin
                        pc <= pc + 32'd4;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (cap_load),
        .flush    (cap_flush),
        .inst     (inst),
        .pc       (pc),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4)
    );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch initiator that drives the word-addressed instruction memory `IM` (32 x 32-bit, asynchronous read). It holds the program counter and presents `pc[6:2]` to `IM`. The returned word is captured into an IF/ID pipeline register with a valid/ready handshake toward decode. It also accepts branch redirects from later stages.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `IM_AW`, 5, IM word-address width; the IM index is `pc[IM_AW+1:2]`.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `addresIM`  out  IM_AW  word address to `IM`; combinational copy of `pc[IM_AW+1:2]`.
- `inst`  in  32  instruction word from `IM`, valid in the same cycle as `addresIM`.
- `branch_taken`  in  1  one-cycle redirect request.
- `branch_target`  in  32  redirect PC; bits [1:0] are ignored and forced to 0.
- `id_ready`  in  1  decode accepts the IF/ID contents this cycle.
- `id_valid`  out  1  IF/ID register holds a valid instruction.
- `id_inst`  out  32  captured instruction.
- `id_pc`  out  32  PC of `id_inst`.
- `id_pc4`  out  32  `id_pc + 4`.
- `halted`  out  1  FSM is in HALT. Tied to 0 when halt support is not compiled in.

## Operation
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts one cycle after reset. No capture; moves to RUN.
  - RUN: normal fetch.
  - HALT: terminal until `rst`.
- Reset values: `pc` = RESET_PC, state = BOOT, `id_valid` = 0, `id_inst` = 0, `id_pc` = 0, `id_pc4` = 4, `halted` = 0.
- A transfer occurs when `id_valid && id_ready`.
- Priority each RUN cycle, highest first:
  1. Redirect (`branch_taken`):
     - `pc` <= {branch_target[31:2], 2'b00}
     - `id_valid` <= 0 (flush)
     - Applies regardless of `id_ready`.
  2. Stall (`id_valid && !id_ready`): `pc` and all IF/ID outputs hold.
  3. Advance:
     - `id_inst` <= `inst`
     - `id_pc` <= `pc`
     - `id_pc4` <= `pc + 4`
     - `id_valid` <= 1
     - `pc` <= `pc + 4`
- Arithmetic: `pc` is 32-bit and wraps modulo 2^32. `addresIM` uses only bits [IM_AW+1:2], so the IM index wraps from 31 back to 0 (PC 0x7C -> 0x80 reads word 0).
- `branch_taken` during BOOT: `pc` loads the target and the state still moves to RUN. There is no capture in that cycle.
- `branch_taken` during HALT is ignored.
- `rst` asserted in any state: at the next edge, all registers take their reset values, including a stalled or valid IF/ID entry.

## Timing
- Fetch latency is one cycle: the address is presented in cycle n and `id_inst` is valid after edge n+1.
- Throughput is one instruction per cycle when `id_ready` is high.
- Redirect penalty:
  - The instruction fetched in the `branch_taken` cycle is discarded.
  - The target is presented in the next cycle.
  - The target's instruction is valid one cycle after that.
- While stalled, `addresIM` stays constant, so `IM` output stays stable.
- `addresIM` has no register stage. All other outputs are registered.

## Configuration
- `FETCH_HALT_EN` defined:
  - In RUN, if the advance path would capture `inst == HALT_WORD` (32'h0000_0000), the word is NOT captured and the state moves to HALT.
  - In HALT: `pc` is frozen, `id_valid` <= 0 once the pending entry transfers, and `halted` = 1.
- `FETCH_HALT_EN` undefined: the HALT state is absent, zero words are fetched like any other word, and `halted` is constant 0.

## Structure
- Shared package `fetch_pkg` contains:
  - the state enum (BOOT, RUN, HALT)
  - `HALT_WORD`
  - the default `RESET_PC`
  - `IM_AW`
- One sub-module, `if_id_reg`, holds `id_inst`/`id_pc`/`id_pc4`/`id_valid` with load, hold and flush controls. PC logic and the FSM stay in `instruction_fetch`.

## Test plan
- Reset then free-run with `id_ready` = 1 and IM loaded with words 0..29: `addresIM` steps 0,1,2,...; `id_pc` = 0,4,8,... one cycle later; `id_inst` matches the IM contents.
- Hold `id_ready` = 0 for 3 cycles while `id_pc` = 0x8: `addresIM` stays 3 and `id_inst`/`id_pc` are unchanged. After release, `id_pc` = 0xC on the next edge.
- `branch_taken` = 1 with `branch_target` = 0x41 at `pc` = 0x10: next `addresIM` = 16 and the next `id_valid` = 0. The following capture has `id_pc` = 0x40.
- Run past PC 0x7C: `addresIM` wraps to 0 and `id_pc` = 0x80 while `id_inst` equals word 0.
- Assert `rst` mid-stall with `id_valid` = 1: the next edge gives `id_valid` = 0 and `pc` = RESET_PC. BOOT lasts one cycle before captures resume.
- With `FETCH_HALT_EN`, word 30 = 0: `halted` rises after the edge at `addresIM` = 30, `id_pc` ends at 0x74 (word 29) and the PC is frozen. Without the macro, the zero word is captured with `id_pc` = 0x78.
